// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM encoding and hex scan-code table for ps2_key_fifo_rx
package ps2_pkg;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int EV_EXT = 9;
  localparam int EV_BRK = 8;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic [7:0] HEX_TABLE [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };
  function automatic logic [4:0] hex_decode(input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (code == HEX_TABLE[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/ps2_key_fifo_rx_if.sv
// ps2_key_fifo_rx_if: key event FIFO read side; nib_* present with PS2_NIBBLE_DECODE_EN
interface ps2_key_fifo_rx_if #(parameter int DEPTH = 8);
  logic rd_en;
  logic [9:0] key_dout;
  logic key_valid;
  logic fifo_full;
  logic [$clog2(DEPTH+1)-1:0] key_count;
  logic overflow;
  logic frame_err;
`ifdef PS2_NIBBLE_DECODE_EN
  logic [3:0] nib_code;
  logic nib_hit;
  modport master(input rd_en, output key_dout, key_valid, fifo_full, key_count, overflow, frame_err, nib_code, nib_hit);
  modport slave(output rd_en, input key_dout, key_valid, fifo_full, key_count, overflow, frame_err, nib_code, nib_hit);
`else
  modport master(input rd_en, output key_dout, key_valid, fifo_full, key_count, overflow, frame_err);
  modport slave(output rd_en, input key_dout, key_valid, fifo_full, key_count, overflow, frame_err);
`endif
endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF sync of ps2c/ps2d, FILTER_LEN glitch filter on clock, falling-edge pulse with data sample
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic data
);
  localparam int CW = $clog2(FILTER_LEN);
  logic [1:0] c_s, d_s;
  logic filt, accept;
  logic [CW-1:0] cnt;
  assign accept = (c_s[1] != filt) && (cnt == CW'(FILTER_LEN-1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_s <= 2'b11;
      d_s <= 2'b11;
      filt <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
      data <= 1'b1;
    end else begin
      c_s <= {c_s[0], ps2c};
      d_s <= {d_s[0], ps2d};
      cnt <= (c_s[1] == filt || accept) ? '0 : cnt + CW'(1);
      if (accept) filt <= c_s[1];
      fall <= accept && filt;
      data <= d_s[1];
    end
endmodule

// File: rtl/ps2_key_fifo_rx.sv
// ps2_key_fifo_rx: PS/2 deframer with watchdog, E0/F0 folding and FWFT event FIFO
// Optional hex nibble decode of the head entry under PS2_NIBBLE_DECODE_EN.
module ps2_key_fifo_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c,
  input  logic ps2d,
  input  logic rx_en,
  ps2_key_fifo_rx_if.master kb
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  localparam int WW = $clog2(TIMEOUT_CYC+1);
  logic [1:0] rs;
  logic rst_n, fall, data;
  state_t state, state_d;
  logic [7:0] shreg;
  logic [2:0] bitn;
  logic par, emit, bad, timeout, ext, brk, push, frame_err, ovf;
  logic [WW-1:0] wd;
  logic [9:0] ev, head;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [NW-1:0] count;
  logic pop, full, wr, prefix;
  // reset asserts asynchronously but releases synchronously
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rs <= 2'b00;
    else rs <= {rs[0], 1'b1};
  assign rst_n = rs[1];
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d), .fall(fall), .data(data)
  );
  assign timeout = (state != S_IDLE) && !fall && (wd == WW'(TIMEOUT_CYC-1));
  always_comb begin
    state_d = state;
    emit = 1'b0;
    bad = 1'b0;
    if (timeout) begin
      state_d = S_IDLE;
      bad = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE:   state_d = (rx_en && !data) ? S_DATA : S_IDLE;
        S_DATA:   state_d = (bitn == 3'd7) ? S_PARITY : S_DATA;
        S_PARITY: state_d = S_STOP;
        default: begin
          state_d = S_IDLE;
          emit = data && (^{shreg, par});
          bad = !(data && (^{shreg, par}));
        end
      endcase
    end
  end
  assign prefix = (shreg == PREFIX_EXT) || (shreg == PREFIX_BRK);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      shreg <= '0;
      bitn <= '0;
      par <= 1'b0;
      wd <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      push <= 1'b0;
      ev <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_d;
      if (fall && state == S_IDLE) bitn <= '0;
      if (fall && state == S_DATA) begin
        shreg <= {data, shreg[7:1]};
        bitn <= bitn + 3'd1;
      end
      if (fall && state == S_PARITY) par <= data;
      wd <= (state == S_IDLE || fall) ? '0 : wd + WW'(1);
      frame_err <= bad;
      push <= emit && !prefix;
      ev <= {ext, brk, shreg};
      if (bad) {ext, brk} <= 2'b00;
      else if (emit) begin
        if (shreg == PREFIX_EXT) ext <= 1'b1;
        else if (shreg == PREFIX_BRK) brk <= 1'b1;
        else {ext, brk} <= 2'b00;
      end
    end
  assign full = count == NW'(DEPTH);
  assign pop = kb.rd_en && count != '0;
  assign wr = push && (!full || pop);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= ev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(pop);
      count <= count + NW'(wr) - NW'(pop);
      if (push && full && !pop) ovf <= 1'b1;
    end
  assign head = (count != '0) ? mem[rp] : '0;
  assign kb.key_dout = head;
  assign kb.key_valid = count != '0;
  assign kb.fifo_full = full;
  assign kb.key_count = count;
  assign kb.overflow = ovf;
  assign kb.frame_err = frame_err;
`ifdef PS2_NIBBLE_DECODE_EN
  logic [4:0] nib;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nib <= '0;
    else nib <= (count != '0 && !head[EV_EXT] && !head[EV_BRK]) ? hex_decode(head[7:0]) : '0;
  assign kb.nib_hit = nib[4];
  assign kb.nib_code = nib[3:0];
`endif
endmodule

// File: tb/tb_ps2_key_fifo_rx.sv
// tb_ps2_key_fifo_rx: directed PS/2 frames against hand-computed FIFO contents and error pulses
module tb_ps2_key_fifo_rx;
  localparam int DEPTH = 4;
  localparam int HP = 20;
  logic clk = 1'b0, reset_n = 1'b0, ps2c = 1'b1, ps2d = 1'b1, rx_en = 1'b1;
  int checks = 0, errors = 0, ferr_hi = 0, f0;
  always #5 clk = ~clk;
  ps2_key_fifo_rx_if #(.DEPTH(DEPTH)) kb();
  ps2_key_fifo_rx #(.FILTER_LEN(8), .DEPTH(DEPTH), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en), .kb(kb)
  );
  always @(posedge clk) if (kb.frame_err) ferr_hi++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic bad = 1'b0, input int n = 11);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      repeat (HP) @(negedge clk);
      ps2c = 1'b0;
      repeat (HP) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (HP) @(negedge clk);
  endtask
  task automatic pop();
    kb.rd_en = 1'b1;
    @(negedge clk);
    kb.rd_en = 1'b0;
    @(negedge clk);
  endtask
  task automatic head(input string tag, input logic [9:0] dout, input int cnt);
    check({tag, "_dout"}, kb.key_dout, dout);
    check({tag, "_cnt"}, kb.key_count, cnt);
  endtask
  task automatic all_zero(input string tag);
    check(tag, {kb.key_dout, kb.key_valid, kb.fifo_full, kb.key_count, kb.overflow, kb.frame_err}, 0);
  endtask
  initial begin
    kb.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h1C);
    head("mk1c", 10'h01C, 1);
    check("mk1c_valid", kb.key_valid, 1);
`ifdef PS2_NIBBLE_DECODE_EN
    check("nib_code", kb.nib_code, 4'hA);
    check("nib_hit", kb.nib_hit, 1);
`endif
    pop();
    head("empty", 10'h000, 0);
    check("empty_valid", kb.key_valid, 0);
    send(8'hF0); send(8'h1C);
    head("brk1c", 10'h11C, 1);
    pop();
    send(8'hE0); send(8'hF0); send(8'h75);
    head("extbrk75", 10'h375, 1);
    pop();
    send(8'hF0);
    f0 = ferr_hi;
    send(8'h1C, 1'b1);
    check("perr_pulse", ferr_hi - f0, 1);
    head("perr_nopush", 10'h000, 0);
    send(8'h16);
    head("after_perr", 10'h016, 1);
    pop();
    f0 = ferr_hi;
    send(8'h00, 1'b0, 6);
    repeat (1100) @(negedge clk);
    check("tmo_pulse", ferr_hi - f0, 1);
    head("tmo_nopush", 10'h000, 0);
    send(8'h45);
    head("after_tmo", 10'h045, 1);
    pop();
    rx_en = 1'b0;
    send(8'h1C);
    head("rx_off", 10'h000, 0);
    rx_en = 1'b1;
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    check("ovf_full", kb.fifo_full, 1);
    check("ovf_cnt", kb.key_count, 4);
    check("ovf_flag", kb.overflow, 1);
    check("ovf_rd0", kb.key_dout, 10'h016); pop();
    check("ovf_rd1", kb.key_dout, 10'h01E); pop();
    check("ovf_rd2", kb.key_dout, 10'h026); pop();
    check("ovf_rd3", kb.key_dout, 10'h025); pop();
    check("ovf_empty", kb.key_valid, 0);
    check("ovf_sticky", kb.overflow, 1);
    send(8'h36); send(8'h3D);
    check("pre_rst_cnt", kb.key_count, 2);
    send(8'h45, 1'b0, 4);
    reset_n = 1'b0;
    #1;
    all_zero("mid_rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h45);
    head("post_rst", 10'h045, 1);
    check("post_rst_ovf", kb.overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
